pwm_sample_player: RTL and testbench
====================================

// Module: pwm_sample_player
// PURPOSE
//   Audio PWM back end in the pwm_clk (150 MHz) domain. Each PWM period it fetches one duty
//   sample, from either the async sample FIFO (streaming) or the CPU duty register
//   (req/ack), and drives a glitch-free PWM bit to the aud_pwm IOB register.
//   Sits between the async FIFO read port / CPU duty handshake and the aud_pwm pin.
// PARAMETERS
//   WIDTH  12  duty/counter width; PWM period = 2**WIDTH clk cycles (4096 -> 36.6 kHz at 150 MHz)
// PORTS
//   clk               in   1      pwm clock; all logic on posedge
//   rst               in   1      synchronous, active-high reset
//   dac_source        in   1      0 = FIFO stream, 1 = CPU duty register
//   rv_duty_cycle     in   WIDTH  CPU duty value, valid while req high
//   req               in   1      CPU requests its duty value be loaded
//   ack               out  1      one-cycle pulse: rv_duty_cycle consumed
//   async_duty_cycle  in   WIDTH  FIFO read data, valid 1 cycle after async_r_en
//   async_empty       in   1      FIFO empty flag
//   async_r_en        out  1      one-cycle FIFO read strobe
//   underrun          out  1      one-cycle pulse: FIFO sample missing, previous duty repeated
//   pwm               out  1      registered PWM output
// BEHAVIOUR
//   - Reset (sync): cnt=0, duty=0, next_duty=0, mode=0, pwm=0, ack=0, async_r_en=0,
//     underrun=0, rd_pend=0. Takes effect on the edge where rst is sampled high; any in-flight
//     FIFO read is dropped (data arriving after reset is ignored).
//   - cnt: free-running WIDTH-bit up counter, wraps from 2**WIDTH-1 to 0. Let LAST = 2**WIDTH-1.
//   - pwm <= (cnt < duty), registered (one cycle after cnt). duty=0 -> constant 0;
//     duty=LAST -> high LAST of every 2**WIDTH cycles. Never 100% high.
//   - duty changes only on the edge where cnt==LAST (period boundary), so no mid-period glitch.
//   - mode <= dac_source on the boundary edge only; mid-period dac_source changes are ignored
//     until the next boundary.
//   - FIFO mode (mode=0):
//       cnt==LAST-2: if !async_empty -> async_r_en=1 for that cycle, rd_pend<=1;
//                    else underrun=1 for that cycle, rd_pend<=0.
//       cnt==LAST-1: if rd_pend -> next_duty <= async_duty_cycle.
//       cnt==LAST  : duty <= next_duty (unchanged on underrun -> previous sample repeats).
//     Exactly <=1 read per period; async_r_en is never high while async_empty is high.
//   - CPU mode (mode=1):
//       cnt==LAST with req=1: duty <= rv_duty_cycle, ack=1 for that one cycle.
//       req=0 at boundary: duty held, no ack. req held high -> one ack per period.
//       async_r_en and underrun stay 0; next_duty tracks duty on each load.
//   - Mode switch at boundary B: the mode used for load decisions at B is the mode
//     in effect before B; the new mode governs the fetch for the period starting after B.
//   - Arithmetic: unsigned compares, WIDTH-bit; no saturation needed.
//   - All outputs are registered; no combinational path from input to output.
// TESTING (WIDTH=4, period 16 for sims)
//   1. Reset, FIFO mode, FIFO holds 5 then 12 -> async_r_en at cnt=13 each period;
//      pwm high 5/16 cycles, then 12/16 cycles.
//   2. FIFO empty at cnt=13 after a sample of 7 -> underrun pulse, no r_en, next period still 7/16.
//   3. dac_source=1, req=1, rv_duty_cycle=9 -> ack single pulse at cnt=15; pwm 9/16;
//      req held high -> one ack per 16 cycles, no FIFO reads.
//   4. duty=0 -> pwm never high; duty=15 -> pwm high 15 of 16 cycles, low at cnt=15.
//   5. rst asserted at cnt=14 right after async_r_en -> next cycle all outputs 0, cnt=0;
//      the arriving FIFO word is not loaded; pwm stays 0 during the next period.
//   6. Toggle dac_source at cnt=6 -> no behaviour change until the boundary; a FIFO read still
//      happens at cnt=13 of the current period.

Source files
------------

// File: rtl/pwm_sample_player.sv
// Audio PWM back end: once per PWM period, fetch a duty sample from the async FIFO or the
// CPU duty register, and drive a registered, glitch-free PWM bit.
module pwm_sample_player #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dac_source,
    input  logic [WIDTH-1:0] rv_duty_cycle,
    input  logic             req,
    output logic             ack,
    input  logic [WIDTH-1:0] async_duty_cycle,
    input  logic             async_empty,
    output logic             async_r_en,
    output logic             underrun,
    output logic             pwm
);

    localparam logic [WIDTH-1:0] CNT_LAST    = {WIDTH{1'b1}};
    // Decision edges sit one cycle ahead so registered strobes are visible at LAST-2 / LAST.
    localparam logic [WIDTH-1:0] CNT_ARM     = CNT_LAST - WIDTH'(3);
    localparam logic [WIDTH-1:0] CNT_CAPTURE = CNT_LAST - WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] next_duty;
    logic             mode;
    logic             rd_pend;

    // Free-running period counter and registered comparator output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            cnt <= cnt + WIDTH'(1);
            pwm <= (cnt < duty);
        end
    end

    // FIFO fetch: at most one read strobe per period, or an underrun pulse when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            async_r_en <= 1'b0;
            underrun   <= 1'b0;
            rd_pend    <= 1'b0;
        end else begin
            async_r_en <= 1'b0;
            underrun   <= 1'b0;
            if (cnt == CNT_ARM && !mode) begin
                if (!async_empty) begin
                    async_r_en <= 1'b1;
                    rd_pend    <= 1'b1;
                end else begin
                    underrun <= 1'b1;
                    rd_pend  <= 1'b0;
                end
            end else if (cnt == CNT_CAPTURE) begin
                rd_pend <= 1'b0;
            end
        end
    end

    // Sample staging, CPU handshake and period-boundary loads of duty and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack       <= 1'b0;
            next_duty <= '0;
            duty      <= '0;
            mode      <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (cnt == CNT_CAPTURE) begin
                if (rd_pend) begin
                    next_duty <= async_duty_cycle;
                end
                if (mode && req) begin
                    ack <= 1'b1;
                end
            end
            if (cnt == CNT_LAST) begin
                mode <= dac_source;
                if (mode) begin
                    // ack is high exactly in this cycle when the CPU value is consumed
                    if (ack) begin
                        duty      <= rv_duty_cycle;
                        next_duty <= rv_duty_cycle;
                    end
                end else begin
                    duty <= next_duty;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_sample_player.sv
// Scoreboard bench for pwm_sample_player: a period-level reference model queues expected
// strobes and per-period PWM high counts; a monitor pops and compares them.
module tb_pwm_sample_player;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned PERIOD = 16;
    localparam int          NPER   = 53;
    localparam logic [2:0]  K_REN  = 3'b001;
    localparam logic [2:0]  K_UND  = 3'b010;
    localparam logic [2:0]  K_ACK  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        longint     cyc;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             dac_source;
    logic [WIDTH-1:0] rv_duty_cycle;
    logic             req;
    logic             ack;
    logic [WIDTH-1:0] async_duty_cycle;
    logic             async_empty;
    logic             async_r_en;
    logic             underrun;
    logic             pwm;

    ev_t    ev_q[$];
    int     pwm_q[$];
    int     fifo_q[$];
    int     mq[$];
    int     checks = 0;
    int     passes = 0;
    longint cyc = 0;
    int     pos = 0;
    int     k = 0;
    bit     armed = 0;

    int m_duty, m_nd, m_mode;
    bit m_fetched;

    always #5 clk = ~clk;

    pwm_sample_player #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .dac_source       (dac_source),
        .rv_duty_cycle    (rv_duty_cycle),
        .req              (req),
        .ack              (ack),
        .async_duty_cycle (async_duty_cycle),
        .async_empty      (async_empty),
        .async_r_en       (async_r_en),
        .underrun         (underrun),
        .pwm              (pwm)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_reset_outputs();
        check("rst_ack", ack, 0);
        check("rst_r_en", async_r_en, 0);
        check("rst_underrun", underrun, 0);
        check("rst_pwm", pwm, 0);
    endtask

    task automatic push_sample(input int v);
        fifo_q.push_back(v);
        mq.push_back(v);
    endtask

    task automatic model_reset();
        m_duty = 0; m_nd = 0; m_mode = 0; m_fetched = 0;
    endtask

    // Scripted periods exercise the named scenarios, later periods are random.
    task automatic stim_step();
        if (k < 13) begin
            if (pos == 0) begin
                case (k)
                    0:  begin push_sample(5); push_sample(12); end
                    2:  push_sample(7);
                    4:  push_sample(0);
                    5:  push_sample(15);
                    6:  push_sample(3);
                    8:  push_sample(4);
                    12: push_sample(11);
                    default: ;
                endcase
            end
            if (pos == 3 && k == 6) begin req = 1'b1; rv_duty_cycle = WIDTH'(9); end
            if (pos == 3 && k == 9) req = 1'b0;
            if (pos == 6 && k == 6) dac_source = 1'b1;
            if (pos == 6 && k == 10) dac_source = 1'b0;
            if (pos == 14 && k == 12) rst = 1'b1;
        end else begin
            if (pos == 0 && ($urandom % 4) != 0) push_sample(int'($urandom_range(0, PERIOD - 1)));
            if (pos == 3) begin
                req = 1'($urandom % 2);
                rv_duty_cycle = WIDTH'($urandom);
            end
            if (pos == 6 && ($urandom % 3) == 0) dac_source = ~dac_source;
        end
    endtask

    // Period-level reference: one fetch decision and one boundary load per period.
    task automatic model_step();
        ev_t e;
        if (rst) begin
            model_reset();
            return;
        end
        if (pos == 12 && m_mode == 0) begin
            if (mq.size() > 0) begin
                e.kind = K_REN; e.cyc = cyc + 1;
                m_nd = mq.pop_front();
                m_fetched = 1;
            end else begin
                e.kind = K_UND; e.cyc = cyc + 1;
                m_fetched = 0;
            end
            ev_q.push_back(e);
        end
        if (pos == 15) begin
            pwm_q.push_back(m_duty);
            if (m_mode == 1) begin
                if (req) begin
                    e.kind = K_ACK; e.cyc = cyc;
                    ev_q.push_back(e);
                    m_duty = int'(rv_duty_cycle);
                end
            end else if (m_fetched) begin
                m_duty = m_nd;
            end
            m_fetched = 0;
            m_mode = int'(dac_source);
        end
    endtask

    initial begin
        rst = 1'b1; dac_source = 1'b0; req = 1'b0; rv_duty_cycle = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs();
        armed = 1;
        while (k < NPER) begin
            stim_step();
            model_step();
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                pos = 0;
                rst = 1'b0;
                check_reset_outputs();
            end else begin
                pos = (pos + 1) % PERIOD;
            end
            if (pos == 0) k++;
        end
        @(negedge clk);
        #1;
        check("events_left", ev_q.size(), 0);
        check("pwm_windows_left", pwm_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // FIFO read port: data appears the cycle after the read strobe.
    initial begin
        logic got;
        async_empty = 1'b1;
        async_duty_cycle = '0;
        forever begin
            @(negedge clk);
            got = async_r_en;
            @(posedge clk);
            #1;
            if (got === 1'b1 && fifo_q.size() > 0) async_duty_cycle = WIDTH'(fifo_q.pop_front());
            else async_duty_cycle = WIDTH'($urandom);
            #2;
            async_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: matches strobes against the event queue and PWM high counts per window.
    initial begin
        int   acc = 0;
        bit   started = 0;
        logic [2:0] obs;
        ev_t  e;
        forever begin
            @(negedge clk);
            if (!armed) continue;
            obs = {ack, underrun, async_r_en};
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                e = ev_q.pop_front();
                check("event_missing", 0, e.kind);
            end
            if (obs != 3'b000) begin
                if (ev_q.size() == 0) begin
                    check("event_unexpected", obs, 0);
                end else begin
                    e = ev_q.pop_front();
                    check("event_kind", obs, e.kind);
                    check("event_cycle", cyc, e.cyc);
                end
            end
            if (async_r_en) check("r_en_while_empty", async_empty, 0);
            if (rst) begin
                acc = 0;
                started = 0;
            end else begin
                if (started) acc += int'(pwm);
                if (pos == 0) begin
                    if (started) begin
                        check("pwm_low_at_wrap", pwm, 0);
                        if (pwm_q.size() == 0) check("pwm_window_unexpected", acc, -1);
                        else check("pwm_high_count", acc, pwm_q.pop_front());
                    end
                    acc = 0;
                    started = 1;
                end
            end
        end
    end

    initial begin
        #(NPER * PERIOD * 10 * 2 + 2000);
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
